// File: rtl/weight_az_multi.sv
// LPC bandwidth expansion: ap[i] = round(a[i] * gamma^i) in Q15, one or two gamma sets
// per start/done transaction, all operands fetched from and results written to scratch memory.
module weight_az_multi #(
  parameter int M      = 10,
  parameter int ADDR_W = 12,
  parameter int MEM_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              dual,
  input  logic [ADDR_W-1:0] A,
  input  logic [ADDR_W-1:0] AP,
  input  logic [ADDR_W-1:0] AP2,
  input  logic [ADDR_W-1:0] gammaAddr,
  input  logic [MEM_W-1:0]  readIn,
  output logic [ADDR_W-1:0] readRequested,
  output logic [ADDR_W-1:0] writeRequested,
  output logic [MEM_W-1:0]  dataOut,
  output logic              write,
  output logic              done,
  output logic              busy,
  output logic [2:0]        o_state
);

  localparam int IW = (M < 2) ? 1 : $clog2(M + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_G_RD  = 3'd1,
    S_G_LAT = 3'd2,
    S_A_RD  = 3'd3,
    S_A_LAT = 3'd4,
    S_WR    = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // Handshake: start is a single-cycle request taken only in IDLE while not already
  // committed (r_busy low); done is a single-cycle completion pulse with busy low.

  state_t            r_state, w_next;
  logic              r_busy, r_set, r_dual;
  logic [ADDR_W-1:0] r_a_base, r_ap_base, r_ap2_base, r_g_base, r_rd_last, w_rd_addr;
  logic [15:0]       r_gam, r_fac, r_coef, w_ap, w_fac_next;
  logic [IW-1:0]     r_i;
  logic              w_accept, w_last;
  logic              w_unused_rd_hi;

  // ITU-style 16x16 -> 32 fractional multiply; only -1 * -1 overflows.
  function automatic logic [31:0] f_mul(input logic [15:0] x, input logic [15:0] y);
    logic signed [31:0] p;
    p = $signed({{16{x[15]}}, x}) * $signed({{16{y[15]}}, y});
    if (x == 16'h8000 && y == 16'h8000) f_mul = 32'h7FFF_FFFF;
    else f_mul = p <<< 1;
  endfunction

  function automatic logic [15:0] f_rnd(input logic [31:0] l);
    logic [32:0] s;
    s = {l[31], l} + 33'h0_0000_8000;
    if (!s[32] && s[31]) f_rnd = 16'h7FFF;
    else f_rnd = s[31:16];
  endfunction

  assign w_unused_rd_hi = ^readIn[MEM_W-1:16];
  assign w_last     = (r_i == IW'(M));
  assign w_accept   = (r_state == S_IDLE) && !r_busy && start;
  assign w_ap       = (r_i == '0) ? r_coef : f_rnd(f_mul(r_coef, r_fac));
  assign w_fac_next = f_rnd(f_mul(r_fac, r_gam));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (r_busy) w_next = S_G_RD;
      S_G_RD:  w_next = S_G_LAT;
      S_G_LAT: w_next = S_A_RD;
      S_A_RD:  w_next = S_A_LAT;
      S_A_LAT: w_next = S_WR;
      S_WR: begin
        if (!w_last) w_next = S_A_RD;
        else if (r_dual && !r_set) w_next = S_G_RD;
        else w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Read address is live only in the RD states and otherwise holds its last value.
  always_comb begin
    w_rd_addr = r_rd_last;
    case (r_state)
      S_G_RD:  w_rd_addr = r_g_base + ADDR_W'(r_set);
      S_A_RD:  w_rd_addr = r_a_base + ADDR_W'(r_i);
      default: w_rd_addr = r_rd_last;
    endcase
  end

  assign readRequested  = w_rd_addr;
  assign write          = (r_state == S_WR);
  assign writeRequested = write ? ((r_set ? r_ap2_base : r_ap_base) + ADDR_W'(r_i)) : '0;
  assign dataOut        = write ? {{(MEM_W-16){w_ap[15]}}, w_ap} : '0;
  assign done           = (r_state == S_DONE);
  assign busy           = r_busy;
  assign o_state        = r_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy     <= 1'b0;
      r_set      <= 1'b0;
      r_dual     <= 1'b0;
      r_a_base   <= '0;
      r_ap_base  <= '0;
      r_ap2_base <= '0;
      r_g_base   <= '0;
      r_rd_last  <= '0;
      r_gam      <= '0;
      r_fac      <= '0;
      r_coef     <= '0;
      r_i        <= '0;
    end else begin
      r_rd_last <= w_rd_addr;
      if (w_accept) begin
        r_a_base   <= A;
        r_ap_base  <= AP;
        r_ap2_base <= AP2;
        r_g_base   <= gammaAddr;
        r_dual     <= dual;
        r_set      <= 1'b0;
        r_busy     <= 1'b1;
      end
      case (r_state)
        S_G_LAT: begin
          r_gam <= readIn[15:0];
          r_fac <= readIn[15:0];
          r_i   <= '0;
        end
        S_A_LAT: r_coef <= readIn[15:0];
        S_WR: begin
          // fac stays gamma^1 through index 1, then advances after each use.
          if (r_i != '0) r_fac <= w_fac_next;
          if (!w_last) r_i <= r_i + IW'(1);
          else if (r_dual && !r_set) r_set <= 1'b1;
          else r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_az_multi.sv
// Bench for weight_az_multi: memory model, write scoreboard fed by a Q15 reference model,
// and directed frames covering timing, saturation, sign, dual mode, reset abort and ignored starts.
module tb_weight_az_multi;

  localparam int M  = 10;
  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          dual = 1'b0;
  logic [AW-1:0] a_b = '0, ap_b = '0, ap2_b = '0, g_b = '0;
  logic [DW-1:0] read_in = '0;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] data_out;
  logic          write, done, busy;
  logic [2:0]    st;

  logic [DW-1:0]    mem [0:(1<<AW)-1];
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] exp_w;
  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;

  weight_az_multi #(.M(M), .ADDR_W(AW), .MEM_W(DW)) dut (
    .clk(clk), .reset(rst_n), .start(start), .dual(dual),
    .A(a_b), .AP(ap_b), .AP2(ap2_b), .gammaAddr(g_b),
    .readIn(read_in), .readRequested(rd_addr), .writeRequested(wr_addr),
    .dataOut(data_out), .write(write), .done(done), .busy(busy), .o_state(st)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  always @(posedge clk) begin
    read_in <= mem[rd_addr];
    if (write === 1'b1) mem[wr_addr] <= data_out;
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (write === 1'b1) begin
      n_writes++;
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_write observed=%h/%h expected=none", wr_addr, data_out);
      end
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        n_checks++;
        assert ({wr_addr, data_out} === exp_w) else begin
          n_fail++;
          $error("FAIL write observed=%h/%h expected=%h/%h",
                 wr_addr, data_out, exp_w[AW+DW-1:DW], exp_w[DW-1:0]);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_mr(input logic [15:0] x, input logic [15:0] y);
    longint l;
    l = longint'($signed(x)) * longint'($signed(y)) * 2;
    if (l > 64'sd2147483647) l = 64'sd2147483647;
    l = l + 32768;
    if (l > 64'sd2147483647) l = 64'sd2147483647;
    l = l >>> 16;
    return l[15:0];
  endfunction

  function automatic logic [31:0] sx(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  task automatic push_set(input logic [AW-1:0] ab, input logic [AW-1:0] ob, input logic [AW-1:0] gb);
    logic [15:0] g, fac, c, v;
    logic [AW-1:0] wa;
    g = mem[gb][15:0];
    fac = g;
    for (int i = 0; i <= M; i++) begin
      c = mem[ab + AW'(i)][15:0];
      v = (i == 0) ? c : ref_mr(c, fac);
      if (i >= 1) fac = ref_mr(fac, g);
      wa = ob + AW'(i);
      exp_q.push_back({wa, sx(v)});
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_frame(input bit d, input logic [AW-1:0] ab, input logic [AW-1:0] apb,
                           input logic [AW-1:0] ap2b, input logic [AW-1:0] gb,
                           input bit stray, input string tag);
    int exp_cyc, w0, n;
    bit got;
    exp_cyc = d ? (3 + 6*(M+1) + 2) : (3 + 3*(M+1));
    for (int i = 0; i <= M; i++) begin
      mem[apb + AW'(i)] = '0;
      if (d) mem[ap2b + AW'(i)] = '0;
    end
    push_set(ab, apb, gb);
    if (d) push_set(ab, ap2b, gb + AW'(1));
    w0 = n_writes;
    @(negedge clk);
    a_b = ab; ap_b = apb; ap2_b = ap2b; g_b = gb; dual = d; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    a_b = AW'($urandom); ap_b = AW'($urandom); ap2_b = AW'($urandom); g_b = AW'($urandom);
    dual = ~d;
    @(negedge clk);
    chk({tag, "_busy_after_start"}, 64'(busy), 64'd1);
    n = 0; got = 1'b0;
    while (!got && n < 300) begin
      @(posedge clk);
      n++;
      #1 start = 1'b0;
      @(negedge clk);
      if (done) got = 1'b1;
      else if (stray && n == 9) start = 1'b1;
    end
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
    chk({tag, "_done_cycle"}, 64'(n), 64'(exp_cyc));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, "_write_count"}, 64'(n_writes - w0), d ? 64'd22 : 64'd11);
    chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    // start coincident with done must be ignored
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    chk({tag, "_start_at_done_ignored"}, 64'(busy), 64'd0);
  endtask

  task automatic fill_random(input logic [AW-1:0] ab, input logic [AW-1:0] gb);
    for (int i = 0; i <= M; i++) mem[ab + AW'(i)] = $urandom();
    mem[gb] = $urandom();
    mem[gb + AW'(1)] = $urandom();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int w0;
    bit found, saw_done;
    logic [31:0] pw;
    for (int j = 0; j < (1<<AW); j++) mem[j] = '0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {61'd0, write, done, busy}, 64'd0);
    chk("reset_state", 64'(st), 64'd0);
    chk("reset_rd_addr", 64'(rd_addr), 64'd0);
    chk("reset_wr_bus", {20'd0, wr_addr, data_out}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // powers of two
    mem[12'h010] = 32'hABCD_4000;
    for (int i = 0; i <= M; i++) mem[12'h100 + i] = 32'h5A5A_4000;
    run_frame(1'b0, 12'h100, 12'h200, 12'h300, 12'h010, 1'b0, "pow2");
    for (int i = 0; i <= M; i++) begin
      pw = 32'h4000 >> i;
      chk($sformatf("pow2_ap%0d", i), 64'(mem[12'h200 + i]), 64'(pw));
    end

    // saturation corner
    mem[12'h010] = 32'h0000_8000;
    for (int i = 0; i <= M; i++) mem[12'h100 + i] = 32'h0000_1111;
    mem[12'h100] = 32'h0000_4000;
    mem[12'h101] = 32'hFFFF_8000;
    mem[12'h102] = 32'h0000_8000;
    run_frame(1'b0, 12'h100, 12'h200, 12'h300, 12'h010, 1'b0, "sat");
    chk("sat_ap1", 64'(mem[12'h201]), 64'h0000_7FFF);
    chk("sat_ap2", 64'(mem[12'h202]), 64'hFFFF_8001);

    // negative coefficient, ap[0] unmodified
    mem[12'h010] = 32'h0000_4000;
    mem[12'h100] = 32'h0000_9ABC;
    mem[12'h101] = 32'h0000_C000;
    run_frame(1'b0, 12'h100, 12'h200, 12'h300, 12'h010, 1'b0, "neg");
    chk("neg_ap0", 64'(mem[12'h200]), 64'hFFFF_9ABC);
    chk("neg_ap1", 64'(mem[12'h201]), 64'hFFFF_E000);

    // dual mode
    mem[12'h010] = 32'h0000_4000;
    mem[12'h011] = 32'h0000_2000;
    for (int i = 0; i <= M; i++) mem[12'h100 + i] = 32'h0000_4000;
    run_frame(1'b1, 12'h100, 12'h200, 12'h300, 12'h010, 1'b0, "dual");
    chk("dual_ap1", 64'(mem[12'h201]), 64'h0000_2000);
    chk("dual_ap10", 64'(mem[12'h20A]), 64'h0000_0010);
    chk("dual_ap2_1", 64'(mem[12'h301]), 64'h0000_1000);
    chk("dual_ap2_2", 64'(mem[12'h302]), 64'h0000_0400);

    // asynchronous reset during write of i = 5
    fill_random(12'h100, 12'h010);
    push_set(12'h100, 12'h200, 12'h010);
    @(negedge clk);
    a_b = 12'h100; ap_b = 12'h200; ap2_b = 12'h300; g_b = 12'h010; dual = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(posedge clk);
      #2;
      if (write === 1'b1 && wr_addr === 12'h205) found = 1'b1;
    end
    chk("rst_mid_reached_i5", 64'(found), 64'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_mid_ctrl", {58'd0, write, done, busy, st}, 64'd0);
    chk("rst_mid_rd_addr", 64'(rd_addr), 64'd0);
    chk("rst_mid_wr_bus", {20'd0, wr_addr, data_out}, 64'd0);
    w0 = n_writes;
    saw_done = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("rst_mid_no_done", 64'(saw_done), 64'd0);
    chk("rst_mid_no_writes", 64'(n_writes - w0), 64'd0);
    chk("rst_mid_idle", 64'(busy), 64'd0);

    fill_random(12'h100, 12'h010);
    run_frame(1'b0, 12'h100, 12'h200, 12'h300, 12'h010, 1'b0, "after_rst");

    // stray start while busy, inputs scrambled while busy
    fill_random(12'h100, 12'h010);
    run_frame(1'b0, 12'h100, 12'h200, 12'h300, 12'h010, 1'b1, "stray_single");
    fill_random(12'h100, 12'h010);
    run_frame(1'b1, 12'h100, 12'h200, 12'h300, 12'h010, 1'b1, "stray_dual");

    // random frames
    for (int f = 0; f < 6; f++) begin
      fill_random(12'h400, 12'h020);
      run_frame(f[0], 12'h400, 12'h500, 12'h600, 12'h020, 1'b0, $sformatf("rand%0d", f));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
